// File: rtl/imem_load_ctrl.sv
// Instruction-memory program loader: streams bytes into IMEM while
// holding the CPU fetch path, with range check and done/error pulses.
module imem_load_ctrl #(
    parameter int MEM_DEPTH = 1025
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ld_start,
    input  logic [63:0] ld_base,
    input  logic [10:0] ld_len,
    input  logic [7:0]  ld_data,
    input  logic        ld_valid,
    output logic        ld_ready,
    output logic        mem_wEn,
    output logic [63:0] mem_waddr,
    output logic [7:0]  mem_wdata,
    input  logic        fetch_req,
    output logic        fetch_gnt,
    output logic        cpu_hold,
    output logic        ld_done,
    output logic        ld_err
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FLUSH,
        DONE
    } state_t;

    localparam logic [64:0] DEPTH_W = 65'(MEM_DEPTH);

    state_t      state_q;
    state_t      state_d;
    logic [63:0] ptr_q;
    logic [10:0] rem_q;
    logic        err_q;
    logic        start_idle;
    logic        range_err;
    logic        accept;
    logic [64:0] end_addr;

    // 65-bit sum so a base near 2^64 cannot wrap into range
    assign end_addr   = {1'b0, ld_base} + {54'd0, ld_len};
    assign range_err  = end_addr > DEPTH_W;
    assign start_idle = ld_start & (state_q == IDLE);
    assign accept     = ld_valid & ld_ready;

    assign ld_ready  = (state_q == LOAD);
    assign cpu_hold  = (state_q != IDLE);
    assign fetch_gnt = fetch_req & (state_q == IDLE);
    assign ld_done   = (state_q == DONE);
    assign ld_err    = err_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_idle && !range_err) begin
                    state_d = (ld_len == 11'd0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (accept && rem_q == 11'd1) begin
                    state_d = FLUSH;
                end
            end
            FLUSH:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= 64'd0;
            rem_q     <= 11'd0;
            err_q     <= 1'b0;
            mem_wEn   <= 1'b0;
            mem_waddr <= 64'd0;
            mem_wdata <= 8'd0;
        end else begin
            state_q <= state_d;
            err_q   <= start_idle & range_err;
            mem_wEn <= accept;
            if (start_idle && !range_err) begin
                ptr_q <= ld_base;
                rem_q <= ld_len;
            end else if (accept) begin
                ptr_q     <= ptr_q + 64'd1;
                rem_q     <= rem_q - 11'd1;
                mem_waddr <= ptr_q;
                mem_wdata <= ld_data;
            end
        end
    end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed-vector bench for imem_load_ctrl; inputs driven and outputs
// sampled around the falling edge.
module tb_imem_load_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ld_start;
    logic [63:0] ld_base;
    logic [10:0] ld_len;
    logic [7:0]  ld_data;
    logic        ld_valid;
    logic        ld_ready;
    logic        mem_wEn;
    logic [63:0] mem_waddr;
    logic [7:0]  mem_wdata;
    logic        fetch_req;
    logic        fetch_gnt;
    logic        cpu_hold;
    logic        ld_done;
    logic        ld_err;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    imem_load_ctrl #(.MEM_DEPTH(1025)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ld_start  (ld_start),
        .ld_base   (ld_base),
        .ld_len    (ld_len),
        .ld_data   (ld_data),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .mem_wEn   (mem_wEn),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .fetch_req (fetch_req),
        .fetch_gnt (fetch_gnt),
        .cpu_hold  (cpu_hold),
        .ld_done   (ld_done),
        .ld_err    (ld_err)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // cycle 0 = the cycle ld_start is high
    task automatic start(input logic [63:0] b, input logic [10:0] l);
        @(negedge clk);
        ld_start = 1'b1;
        ld_base  = b;
        ld_len   = l;
        #1;
    endtask

    task automatic next_cyc();
        @(negedge clk);
        ld_start = 1'b0;
    endtask

    logic [7:0] prog [4];
    int         wr_cnt;
    int         done_at;
    logic [63:0] last_addr;
    logic [3:0] vpat;

    initial begin
        prog[0] = 8'h30; prog[1] = 8'hF4;
        prog[2] = 8'h0E; prog[3] = 8'h00;
        rst_n = 1'b0; ld_start = 1'b0; ld_base = '0; ld_len = '0;
        ld_data = '0; ld_valid = 1'b0; fetch_req = 1'b0;

        // reset state
        #12;
        chk("rst_ready", ld_ready, 0);
        chk("rst_wen", mem_wEn, 0);
        chk("rst_waddr", mem_waddr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_hold", cpu_hold, 0);
        chk("rst_done", ld_done, 0);
        chk("rst_err", ld_err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // base 0 len 4, fetch held high, stray start mid-load
        fetch_req = 1'b1;
        ld_valid  = 1'b1;
        start(64'd0, 11'd4);
        chk("l4_gnt0", fetch_gnt, 1);
        chk("l4_hold0", cpu_hold, 0);
        for (int c = 1; c <= 7; c++) begin
            next_cyc();
            ld_data = (c <= 4) ? prog[c-1] : 8'h00;
            if (c == 3) begin
                ld_start = 1'b1;
                ld_base  = 64'd500;
                ld_len   = 11'd1;
            end
            #1;
            chk($sformatf("l4_hold%0d", c), cpu_hold, (c <= 6) ? 1 : 0);
            chk($sformatf("l4_gnt%0d", c), fetch_gnt, (c > 6) ? 1 : 0);
            chk($sformatf("l4_rdy%0d", c), ld_ready, (c <= 4) ? 1 : 0);
            chk($sformatf("l4_wen%0d", c), mem_wEn,
                (c >= 2 && c <= 5) ? 1 : 0);
            chk($sformatf("l4_done%0d", c), ld_done, (c == 6) ? 1 : 0);
            if (c >= 2 && c <= 5) begin
                chk($sformatf("l4_addr%0d", c), mem_waddr, 64'(c - 2));
                chk($sformatf("l4_data%0d", c), mem_wdata, prog[c-2]);
            end
        end
        fetch_req = 1'b0;

        // out of range: 1020 + 6 > 1025
        start(64'd1020, 11'd6);
        for (int c = 1; c <= 3; c++) begin
            next_cyc();
            #1;
            chk($sformatf("err_err%0d", c), ld_err, (c == 1) ? 1 : 0);
            chk($sformatf("err_wen%0d", c), mem_wEn, 0);
            chk($sformatf("err_hold%0d", c), cpu_hold, 0);
        end

        // exactly fits: 1019 + 6 = 1025
        start(64'd1019, 11'd6);
        wr_cnt = 0; done_at = -1; last_addr = '0;
        for (int c = 1; c <= 20 && done_at < 0; c++) begin
            next_cyc();
            ld_data = 8'(c);
            #1;
            if (mem_wEn) begin
                wr_cnt++;
                last_addr = mem_waddr;
            end
            if (ld_done) done_at = c;
        end
        chk("fit_done_cyc", 64'(done_at), 64'd8);
        chk("fit_writes", 64'(wr_cnt), 64'd6);
        chk("fit_last_addr", last_addr, 64'd1024);
        chk("fit_err", ld_err, 0);

        // zero length
        start(64'd7, 11'd0);
        wr_cnt = 0;
        for (int c = 1; c <= 3; c++) begin
            next_cyc();
            #1;
            if (mem_wEn) wr_cnt++;
            chk($sformatf("z_done%0d", c), ld_done, (c == 1) ? 1 : 0);
            chk($sformatf("z_hold%0d", c), cpu_hold, (c == 1) ? 1 : 0);
        end
        chk("z_writes", 64'(wr_cnt), 0);

        // valid pattern 1,0,0,1 with len 2
        vpat = 4'b1001;
        start(64'd100, 11'd2);
        for (int c = 1; c <= 7; c++) begin
            next_cyc();
            ld_valid = (c <= 4) ? vpat[4-c] : 1'b1;
            ld_data  = 8'(8'hA0 + c);
            #1;
            chk($sformatf("v_wen%0d", c), mem_wEn,
                (c == 2 || c == 5) ? 1 : 0);
            if (c == 2) begin
                chk("v_addr2", mem_waddr, 64'd100);
                chk("v_data2", mem_wdata, 64'hA1);
            end
            if (c == 5) begin
                chk("v_addr5", mem_waddr, 64'd101);
                chk("v_data5", mem_wdata, 64'hA4);
            end
            chk($sformatf("v_done%0d", c), ld_done, (c == 6) ? 1 : 0);
        end

        // reset after two of five bytes
        ld_valid = 1'b1;
        start(64'd10, 11'd5);
        next_cyc();
        next_cyc();
        next_cyc();
        #1;
        chk("ra_wen_pre", mem_wEn, 1);
        chk("ra_addr_pre", mem_waddr, 64'd11);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ra_wen", mem_wEn, 0);
        chk("ra_waddr", mem_waddr, 0);
        chk("ra_hold", cpu_hold, 0);
        chk("ra_ready", ld_ready, 0);
        chk("ra_done", ld_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        done_at = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            if (ld_done || mem_wEn) done_at++;
        end
        chk("ra_quiet", 64'(done_at), 0);

        start(64'd0, 11'd2);
        done_at = -1; wr_cnt = 0;
        for (int c = 1; c <= 20 && done_at < 0; c++) begin
            next_cyc();
            #1;
            if (mem_wEn) wr_cnt++;
            if (ld_done) done_at = c;
        end
        chk("rb_done_cyc", 64'(done_at), 64'd4);
        chk("rb_writes", 64'(wr_cnt), 64'd2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/imem_load_ctrl.md
IMEM_LOAD_CTRL -- requirements
Module: imem_load_ctrl

Interface
REQ-001 Parameter MEM_DEPTH, default 1025: number of byte locations in the instruction memory, addresses 0..MEM_DEPTH-1.
REQ-002 clk  input  1  single clock; all state SHALL change on the rising edge.
REQ-003 rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-004 ld_start  input  1  one-cycle pulse requesting a program load.
REQ-005 ld_base  input  64  first byte address of the load, sampled when ld_start is accepted.
REQ-006 ld_len  input  11  byte count of the load, sampled when ld_start is accepted.
REQ-007 ld_data  input  8  stream byte.
REQ-008 ld_valid  input  1  ld_data is valid.
REQ-009 ld_ready  output  1  controller accepts ld_data this cycle.
REQ-010 mem_wEn  output  1  instruction-memory byte write strobe.
REQ-011 mem_waddr  output  64  write byte address.
REQ-012 mem_wdata  output  8  write byte.
REQ-013 fetch_req  input  1  fetch stage requests memory read.
REQ-014 fetch_gnt  output  1  fetch read permitted this cycle.
REQ-015 cpu_hold  output  1  PC/fetch stall while a load is in progress.
REQ-016 ld_done  output  1  one-cycle pulse: load complete.
REQ-017 ld_err  output  1  one-cycle pulse: load rejected, out of range.

Function
REQ-018 States: IDLE, LOAD, FLUSH, DONE; state SHALL be registered.
REQ-019 IDLE + ld_start: if ld_base+ld_len > MEM_DEPTH (65-bit compare, no wrap), ld_err=1 next cycle, stay IDLE, no writes.
REQ-020 IDLE + ld_start, in range, ld_len=0 -> DONE; ld_done=1 next cycle; no writes.
REQ-021 IDLE + ld_start, in range, ld_len>0 -> LOAD; capture base into addr pointer, ld_len into remaining counter.
REQ-022 ld_ready=1 only in LOAD; a byte is accepted when ld_valid & ld_ready.
REQ-023 Accepted byte SHALL appear on mem_wEn=1/mem_waddr/mem_wdata exactly one cycle later (registered); pointer +1, remaining -1 per accept.
REQ-024 mem_wEn=0 in every cycle not following an accept; mem_waddr/mem_wdata hold last value.
REQ-025 ld_valid=0 in LOAD: stall, no write, counters hold; no timeout.
REQ-026 Accept with remaining=1 -> FLUSH (last write issued in FLUSH cycle) -> DONE; ld_ready=0 in FLUSH.
REQ-027 DONE: ld_done=1 for exactly one cycle, then IDLE.
REQ-028 cpu_hold=1 in LOAD, FLUSH, DONE; 0 in IDLE.
REQ-029 fetch_gnt = fetch_req & (state==IDLE); loader always wins; combinational from state.
REQ-030 ld_start outside IDLE SHALL be ignored (no restart, no error).
REQ-031 ld_start and fetch_req in same IDLE cycle: fetch_gnt=1 that cycle; hold begins next cycle.
REQ-032 Total latency, ld_start to ld_done, with ld_valid held high: ld_len+2 cycles.

Reset
REQ-033 rst_n=0 SHALL immediately force IDLE, ld_ready=0, mem_wEn=0, mem_waddr=0, mem_wdata=0, ld_done=0, ld_err=0, cpu_hold=0, counters=0.
REQ-034 Reset mid-load aborts without ld_done; bytes already written stay in memory; pending registered write is dropped.
REQ-035 After rst_n rises, first ld_start is honoured on the first rising edge.

Verification
REQ-036 Load base=0, len=4, bytes 30 F4 0E 00, ld_valid high -> writes addr 0..3 on cycles 2..5 after start, ld_done on cycle 6, cpu_hold 1 cycles 1..6.
REQ-037 base=1020, len=6 -> ld_err pulse, no mem_wEn, cpu_hold stays 0; base=1019, len=6 -> accepted, last write addr 1024.
REQ-038 len=0 -> ld_done next cycle, zero writes.
REQ-039 ld_valid toggled 1,0,0,1 with len=2 -> exactly two writes, addresses consecutive, no write in stall cycles.
REQ-040 fetch_req held high through a load -> fetch_gnt 1 before start, 0 during LOAD..DONE, 1 again after.
REQ-041 rst_n low after 2 of 5 bytes -> outputs zero asynchronously, no ld_done; new load after reset completes normally.
